// File: rtl/circle_pt_counter_pkg.sv
// Shared definitions for the circle point counter: sequencer states,
// set-relation mode codes, default geometry and the per-axis distance helper.
package circle_pt_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] MODE_UNION = 2'd0;
   localparam logic [1:0] MODE_AND   = 2'd1;
   localparam logic [1:0] MODE_XOR   = 2'd2;

   localparam int DEF_GRID_N = 8;
   localparam int DEF_RADIUS = 4;
   localparam int DEF_CNT_W  = 7;

   // Squared distance along one axis between a grid coordinate and a centre.
   // The difference is formed in 5-bit signed so off-grid centres (0, 9..15)
   // still give the correct magnitude before squaring.
   function automatic logic [9:0] axisSq(input logic [3:0] p, input logic [3:0] c);
      logic signed [4:0] diff;
      logic [4:0]        mag;
      diff = $signed({1'b0, p}) - $signed({1'b0, c});
      mag  = diff[4] ? 5'(~diff + 5'sd1) : 5'(diff);
      return 10'(mag) * 10'(mag);
   endfunction

endpackage

// File: rtl/circle_pt_counter_det_inside.sv
// Point-in-circle detector: high when the test point lies inside (or on)
// both circles of the given radius. Tying both centres to the same circle
// turns it into a plain single-circle membership test.
module det_inside
   import circle_pt_counter_pkg::*;
#(
   parameter int RADIUS = DEF_RADIUS
) (
   input  logic [3:0] circle1x_i,
   input  logic [3:0] circle1y_i,
   input  logic [3:0] circle2x_i,
   input  logic [3:0] circle2y_i,
   input  logic [3:0] px_i,
   input  logic [3:0] py_i,
   output logic       inside_o
);

   localparam logic [10:0] RADIUS_SQ = 11'(RADIUS * RADIUS);

   logic [10:0] distOne;
   logic [10:0] distTwo;

   // Squared Euclidean distance to each centre, compared against r^2 so the
   // boundary counts as inside.
   always_comb begin
      distOne  = 11'(axisSq(px_i, circle1x_i)) + 11'(axisSq(py_i, circle1y_i));
      distTwo  = 11'(axisSq(px_i, circle2x_i)) + 11'(axisSq(py_i, circle2y_i));
      inside_o = (distOne <= RADIUS_SQ) && (distTwo <= RADIUS_SQ);
   end

endmodule

// File: rtl/circle_pt_counter.sv
// Grid-scan stage: accepts two circle centres, visits every lattice point of
// a GRID_N x GRID_N grid one per cycle, counts points meeting the selected
// set relation and hands the count downstream.
module circle_pt_counter
   import circle_pt_counter_pkg::*;
#(
   parameter int GRID_N = DEF_GRID_N,
   parameter int RADIUS = DEF_RADIUS,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [3:0]       c1x,
   input  logic [3:0]       c1y,
   input  logic [3:0]       c2x,
   input  logic [3:0]       c2y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output logic             busy
);

   localparam logic [3:0] LAST_COORD = 4'(GRID_N);

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [3:0]       c1x_q, c1x_d, c1y_q, c1y_d;
   logic [3:0]       c2x_q, c2x_d, c2y_q, c2y_d;
   logic [3:0]       px_q, px_d, py_q, py_d;
   logic [CNT_W-1:0] accum_q, accum_d;

   logic memberOne;
   logic memberTwo;
   logic hit;

   det_inside #(.RADIUS(RADIUS)) u_in_c1 (
      .circle1x_i (c1x_q),
      .circle1y_i (c1y_q),
      .circle2x_i (c1x_q),
      .circle2y_i (c1y_q),
      .px_i       (px_q),
      .py_i       (py_q),
      .inside_o   (memberOne)
   );

   det_inside #(.RADIUS(RADIUS)) u_in_c2 (
      .circle1x_i (c2x_q),
      .circle1y_i (c2y_q),
      .circle2x_i (c2x_q),
      .circle2y_i (c2y_q),
      .px_i       (px_q),
      .py_i       (py_q),
      .inside_o   (memberTwo)
   );

   // Combine the two memberships with the registered relation; the reserved
   // code falls back to union.
   always_comb begin
      hit = memberOne | memberTwo;
      case (mode_q)
         MODE_AND: hit = memberOne & memberTwo;
         MODE_XOR: hit = memberOne ^ memberTwo;
         default:  hit = memberOne | memberTwo;
      endcase
   end

   // Sequencer: capture the command in IDLE, walk the grid row by row in
   // SCAN accumulating hits, then hold the result in DONE until taken.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      c1x_d   = c1x_q;
      c1y_d   = c1y_q;
      c2x_d   = c2x_q;
      c2y_d   = c2y_q;
      px_d    = px_q;
      py_d    = py_q;
      accum_d = accum_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mode_d  = mode;
               c1x_d   = c1x;
               c1y_d   = c1y;
               c2x_d   = c2x;
               c2y_d   = c2y;
               px_d    = 4'd1;
               py_d    = 4'd1;
               accum_d = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            accum_d = accum_q + CNT_W'(hit);
            if (px_q == LAST_COORD) begin
               px_d = 4'd1;
               if (py_q == LAST_COORD) begin
                  state_d = ST_DONE;
               end else begin
                  py_d = py_q + 4'd1;
               end
            end else begin
               px_d = px_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_UNION;
         c1x_q   <= '0;
         c1y_q   <= '0;
         c2x_q   <= '0;
         c2y_q   <= '0;
         px_q    <= 4'd1;
         py_q    <= 4'd1;
         accum_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         c1x_q   <= c1x_d;
         c1y_q   <= c1y_d;
         c2x_q   <= c2x_d;
         c2y_q   <= c2y_d;
         px_q    <= px_d;
         py_q    <= py_d;
         accum_q <= accum_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign count     = accum_q;

endmodule

// File: tb/tb_circle_pt_counter.sv
// Self-checking bench for circle_pt_counter: a per-point geometric model
// supplies expected counts, a monitor checks every presented result, and
// directed commands pin latency, handshakes and hand-computed counts.
module tb_circle_pt_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] mode;
   logic [3:0] c1x, c1y, c2x, c2y;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] count;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;
   int expCount   = 0;
   bit monitorOn  = 1'b0;

   circle_pt_counter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .c1x       (c1x),
      .c1y       (c1y),
      .c2x       (c2x),
      .c2y       (c2y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .busy      (busy)
   );

   // 10 time-unit clock.
   always #5 clk = ~clk;

   // Geometric reference: test each lattice point against both circles with
   // plain integer arithmetic and apply the set relation.
   function automatic int modelCount(input int m, input int ax, input int ay,
                                     input int bx, input int by);
      int total;
      bit inA, inB, h;
      total = 0;
      for (int y = 1; y <= 8; y++) begin
         for (int x = 1; x <= 8; x++) begin
            inA = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= 16;
            inB = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= 16;
            case (m)
               1:       h = inA & inB;
               2:       h = inA ^ inB;
               default: h = inA | inB;
            endcase
            total += int'(h);
         end
      end
      return total;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Whenever a result is on offer, it must equal the model's prediction.
   always @(negedge clk) begin
      if (monitorOn && !rst && out_valid) begin
         checkOutput("stream_count", int'(count), expCount);
      end
   end

   // Issue one command, measure latency, optionally stall in DONE and poke
   // in_valid while busy, then complete the output handshake.
   task automatic applyStimulus(input int m, input int ax, input int ay,
                                input int bx, input int by, input int lit,
                                input int holdN, input bit pulse, output int got);
      int cycles;
      expCount = modelCount(m, ax, ay, bx, by);
      cycles = 0;
      while (!in_ready && cycles < 200) begin
         @(posedge clk); #1; cycles++;
      end
      checkOutput("ready_before_cmd", int'(in_ready), 1);
      mode     = 2'(m);
      c1x      = 4'(ax);
      c1y      = 4'(ay);
      c2x      = 4'(bx);
      c2y      = 4'(by);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 200) begin
         if (pulse && cycles == 10) begin
            in_valid = 1'b1;
            c1x = 4'd0; c1y = 4'd0; c2x = 4'd0; c2y = 4'd0; mode = 2'd2;
            checkOutput("ready_low_in_scan", int'(in_ready), 0);
            checkOutput("busy_in_scan", int'(busy), 1);
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1; cycles++;
      end
      in_valid = 1'b0;
      checkOutput("latency", cycles, 64);
      got = int'(count);
      if (lit >= 0) checkOutput("literal_count", got, lit);
      for (int k = 0; k < holdN; k++) begin
         in_valid = pulse && (k == 3);
         @(posedge clk); #1;
         checkOutput("hold_valid", int'(out_valid), 1);
         checkOutput("hold_count", int'(count), got);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("valid_drop", int'(out_valid), 0);
      checkOutput("ready_after", int'(in_ready), 1);
   endtask

   int r0, r1, r2, s1, s2;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0;
      c1x = '0; c1y = '0; c2x = '0; c2y = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_count", int'(count), 0);
      checkOutput("rst_busy", int'(busy), 0);
      rst = 1'b0;
      monitorOn = 1'b1;

      // Coincident centres.
      applyStimulus(0, 4, 4, 4, 4, 47, 0, 1'b0, r0);
      applyStimulus(1, 4, 4, 4, 4, 47, 0, 1'b0, r1);
      applyStimulus(2, 4, 4, 4, 4, 0,  0, 1'b0, r2);

      // Opposite corners, disjoint circles.
      applyStimulus(0, 1, 1, 8, 8, 34, 0, 1'b0, r0);
      applyStimulus(1, 1, 1, 8, 8, 0,  0, 1'b0, r1);
      applyStimulus(2, 1, 1, 8, 8, 34, 0, 1'b0, r2);

      // Overlapping circles: set identities against single-circle counts.
      applyStimulus(0, 4, 4, 5, 4, -1, 0, 1'b0, r0);
      applyStimulus(1, 4, 4, 5, 4, -1, 0, 1'b0, r1);
      applyStimulus(2, 4, 4, 5, 4, -1, 0, 1'b0, r2);
      s1 = modelCount(0, 4, 4, 4, 4);
      s2 = modelCount(0, 5, 4, 5, 4);
      checkOutput("union_plus_and", r0 + r1, s1 + s2);
      checkOutput("xor_identity", r2, r0 - r1);

      // Stall in DONE with in_valid pokes during SCAN and DONE.
      applyStimulus(0, 4, 4, 4, 4, 47, 10, 1'b1, r0);

      // Reset part-way through a scan.
      mode = 2'd1; c1x = 4'd4; c1y = 4'd4; c2x = 4'd4; c2y = 4'd4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrst_in_ready", int'(in_ready), 1);
      checkOutput("midrst_count", int'(count), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      applyStimulus(2, 1, 1, 8, 8, 34, 0, 1'b0, r0);

      // Off-grid centres and the reserved mode code.
      applyStimulus(0, 15, 15, 15, 15, 0, 0, 1'b0, r0);
      applyStimulus(3, 1, 1, 8, 8, 34, 0, 1'b0, r0);

      monitorOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/circle_pt_counter.md
Name: circle_pt_counter

Overview:
- Grid-scan stage that drives the point-in-circle test and consumes its result.
- Accepts two circle centres through a valid/ready handshake and walks every lattice point of a GRID_N x GRID_N grid, one point per cycle.
- Counts the points that satisfy the selected set relation: union, intersection or exactly-one.
- Returns the count downstream through a valid/ready handshake. Sits between the command front end and the result output logic.

Parameters:
- GRID_N, 8, grid side; coordinates run 1..GRID_N inclusive.
- RADIUS, 4, circle radius, passed to both inside-test instances.
- CNT_W, 7, count width; must hold GRID_N*GRID_N (64).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command (high only in IDLE).
- mode  in  2  0 = union, 1 = intersection, 2 = exactly-one (xor), 3 = reserved, treated as union.
- c1x, c1y, c2x, c2y  in  4 each  circle centres, unsigned.
- out_valid  out  1  count valid.
- out_ready  in  1  downstream accepts count.
- count  out  CNT_W  number of qualifying points.
- busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, count=0, busy=0, state=IDLE, px=py=1.
- Reset mid-operation: any state returns to IDLE next edge. Count is cleared, and the held command is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register mode and the four centres, clear the accumulator, set px=1 and py=1, go to SCAN.
  - Inputs are sampled only on that handshake edge. Later changes are ignored.
- SCAN:
  - in_ready=0. Current point is (px,py).
  - Membership m1 = point inside circle 1; m2 = point inside circle 2. Each comes from a separate inside-test instance with both centre inputs tied to the same circle.
  - Hit rule: union m1|m2, intersection m1&m2, xor m1^m2.
  - On each SCAN edge, add hit to the accumulator in the same cycle, so the inside test is combinational with zero added latency.
  - Scan order: px increments 1..GRID_N. On px==GRID_N, px wraps to 1 and py increments.
  - The point (GRID_N,GRID_N) is the last one. Its hit is accumulated and the state goes to DONE.
  - A SCAN phase takes exactly GRID_N*GRID_N cycles (64).
- DONE:
  - out_valid=1, and count equals the final accumulator.
  - Hold both stable until out_valid&&out_ready. On that edge go to IDLE and drop out_valid.
  - If out_ready is already high on the first DONE cycle, the handshake completes in that cycle.
- Latency: input handshake at edge 0 → out_valid high after edge 64 (65th cycle).
- Back-to-back: the earliest next accept is the first IDLE cycle after the output handshake. There is no overlap.
- Width rules:
  - Centre displacement is computed in 5-bit signed, then taken as absolute value.
  - Centres of 0 or 9..15 are legal. Off-grid centres simply produce fewer hits.
  - The accumulator saturates at 64 by construction, so there is no wrap.
- Simultaneous in_valid while busy: ignored; in_ready is low.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE/SCAN/DONE);
  - the mode constants (MODE_UNION=0, MODE_AND=1, MODE_XOR=2);
  - default GRID_N, RADIUS and CNT_W.
- Sub-module: det_inside, the existing block, instantiated twice with RADIUS passed through.
  - Instance u_in_c1: circle1 and circle2 inputs both tied to (c1x,c1y).
  - Instance u_in_c2: both inputs tied to (c2x,c2y).
  - Both instances take (px,py) as the test point.
- All sequencing and accumulation live in the top module.

Test Plan:
1. c1=c2=(4,4), mode 0 → count=47. mode 1 → 47. mode 2 → 0. out_valid rises exactly 64 cycles after the accept edge.
2. c1=(1,1), c2=(8,8): mode 0 → 34, mode 1 → 0, mode 2 → 34.
3. c1=(4,4), c2=(5,4): check each mode against the scoreboard's per-point model. Union plus intersection must equal the sum of the single-circle counts, and xor must equal union minus intersection.
4. Hold out_ready=0 for 10 cycles in DONE: count and out_valid stay stable. Pulse in_valid during SCAN and DONE: no accept, and the result is unchanged.
5. Assert rst at scan cycle 30, then issue a new command: in_ready=1 and count=0 after reset. The new result is independent of the aborted scan.
6. c1=c2=(15,15), off-grid, mode 0 → count=0. mode=3 behaves identically to mode 0 for test 2 centres (34).
